comp_result_collector: RTL and testbench

- Sink at the far end of a weight_comp_cell systolic chain.
- Samples the chain's flagged result bus every cycle and captures only the words whose valid flag is set.
- Buffers those words in a small FIFO and hands them to the downstream consumer over a valid/ready handshake, tagging the last result of each frame.
- Reports frame completion and a sticky overflow/excess-result flag.

---
 rtl/comp_pkg.sv | 23 ++
 rtl/comp_result_collector_fifo.sv | 60 ++++++
 rtl/comp_result_collector.sv | 125 ++++++++++++
 tb/tb_comp_result_collector.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// comp_pkg : shared result-bus types and collector FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package comp_pkg;

  localparam int DEFAULT_RESULT_WIDTH = 32;
  localparam int RESULT_VALID_BIT     = DEFAULT_RESULT_WIDTH;

  typedef struct packed {
    logic                            valid;
    logic [DEFAULT_RESULT_WIDTH-1:0] payload;
  } result_bus_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } collector_state_t;

endpackage
`default_nettype wire

// File: rtl/comp_result_collector_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// result_fifo : first-word fall-through FIFO with same-cycle push/pop
// Rev 1.0
// ----------------------------------------------------------------------------
module result_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == C_DEPTH);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot on the same edge, so a full FIFO still accepts a push.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/comp_result_collector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// comp_result_collector : captures flagged chain results, frames and buffers them
// Rev 1.0
// ----------------------------------------------------------------------------
module comp_result_collector
  import comp_pkg::*;
#(
  parameter int RESULT_WIDTH = DEFAULT_RESULT_WIDTH,
  parameter int FIFO_DEPTH   = 8,
  parameter int RESULT_COUNT = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [RESULT_WIDTH:0]              input_result,
  input  logic                               input_enable,
  output logic [RESULT_WIDTH-1:0]            out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               frame_done,
  output logic                               overflow,
  output logic [$clog2(RESULT_COUNT+1)-1:0]  result_count
);

  localparam int             CW          = $clog2(RESULT_COUNT+1);
  localparam logic [CW-1:0]  C_FRAME_LEN = CW'(RESULT_COUNT);

  collector_state_t          r_state;
  collector_state_t          w_state_nxt;
  logic [RESULT_WIDTH:0]     r_cap;
  logic [CW-1:0]             r_count;
  logic [CW-1:0]             w_count_nxt;
  logic                      r_frame_done;
  logic                      r_overflow;
  logic                      w_overflow_nxt;
  logic                      w_cand;
  logic                      w_push_req;
  logic                      w_accept;
  logic                      w_tag_last;
  logic                      w_pop;
  logic                      w_pop_last;
  logic                      w_drain_exit;
  logic                      w_full;
  logic                      w_empty;
  logic [RESULT_WIDTH:0]     w_head;
  logic [$clog2(FIFO_DEPTH):0] w_unused_count;
  logic                      w_unused_enable;

  assign w_unused_enable = input_enable;

  result_fifo #(
    .WIDTH (RESULT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_data  ({w_tag_last, r_cap[RESULT_WIDTH-1:0]}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_unused_count)
  );

  assign out_valid    = !w_empty;
  assign out_data     = w_head[RESULT_WIDTH-1:0];
  assign out_last     = w_head[RESULT_WIDTH];
  assign frame_done   = r_frame_done;
  assign overflow     = r_overflow;
  assign result_count = r_count;

  assign w_cand     = r_cap[RESULT_WIDTH];
  assign w_pop      = out_valid && out_ready;
  assign w_pop_last = w_pop && w_head[RESULT_WIDTH];
  assign w_tag_last = ((r_count + CW'(1)) == C_FRAME_LEN);
  assign w_accept   = w_push_req && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cap        <= '0;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cap        <= input_result;
      r_count      <= w_count_nxt;
      r_frame_done <= w_drain_exit;
      r_overflow   <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    w_push_req     = 1'b0;
    w_drain_exit   = 1'b0;
    case (r_state)
      ST_IDLE, ST_COLLECT: begin
        w_push_req = w_cand;
        if (w_push_req && !w_accept) w_overflow_nxt = 1'b1;
        if (w_accept) begin
          w_count_nxt = r_count + CW'(1);
          w_state_nxt = w_tag_last ? ST_DRAIN : ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        // Anything arriving here, including a next frame's first word, is excess.
        if (w_cand) w_overflow_nxt = 1'b1;
        if (w_pop_last) begin
          w_drain_exit = 1'b1;
          w_count_nxt  = '0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_comp_result_collector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_comp_result_collector : randomized bench with a queue-based reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_comp_result_collector;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W:0]    input_result = '0;
  logic          input_enable = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid, out_last, frame_done, overflow;
  logic [1:0]    result_count;

  logic [W:0]    in2 = '0;
  logic          rdy2 = 1'b0;
  logic [W-1:0]  d2;
  logic          v2, l2, fd2, ov2;
  logic [2:0]    rc2;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [W-1:0] popped[$];

  logic [W:0] mq[$];
  int         m_cnt = 0;
  bit         m_drain = 0, m_ovf = 0, m_fd = 0;
  logic [W:0] m_cap = '0;

  always #5 clk = ~clk;

  comp_result_collector #(.RESULT_WIDTH(W), .FIFO_DEPTH(D), .RESULT_COUNT(RC)) dut (
    .clk(clk), .rst(rst), .input_result(input_result), .input_enable(input_enable),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_done(frame_done), .overflow(overflow), .result_count(result_count));

  comp_result_collector #(.RESULT_WIDTH(W), .FIFO_DEPTH(2), .RESULT_COUNT(4)) dut_small (
    .clk(clk), .rst(rst), .input_result(in2), .input_enable(1'b0),
    .out_data(d2), .out_valid(v2), .out_ready(rdy2), .out_last(l2),
    .frame_done(fd2), .overflow(ov2), .result_count(rc2));

  // Reference model: a frame is RC flagged words; the collector refuses words while
  // its finished frame is still queued, and a full queue refuses words unless popping.
  always @(posedge clk) begin : model
    bit pop, plast, push, nfd;
    if (rst) begin
      mq.delete(); m_cnt = 0; m_drain = 0; m_ovf = 0; m_fd = 0; m_cap = '0;
    end else begin
      pop   = (mq.size() > 0) && out_ready;
      plast = pop && mq[0][W];
      nfd   = m_drain && plast;
      push  = 0;
      if (m_cap[W]) begin
        if (m_drain) m_ovf = 1;
        else if (mq.size() == D && !pop) m_ovf = 1;
        else push = 1;
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        m_cnt++;
        mq.push_back({m_cnt == RC, m_cap[W-1:0]});
        if (m_cnt == RC) m_drain = 1;
      end
      if (nfd) begin m_drain = 0; m_cnt = 0; end
      m_fd  = nfd;
      m_cap = input_result;
    end
  end

  always @(posedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) popped.push_back(out_data);
    if (rst === 1'b0 && frame_done === 1'b1) fd_cnt++;
  end

  function automatic logic [37:0] dut_obs();
    return {out_valid, out_valid & out_last, out_valid ? out_data : 32'h0,
            frame_done, overflow, result_count};
  endfunction

  function automatic logic [37:0] mdl_obs();
    logic [W:0] h;
    h = (mq.size() > 0) ? mq[0] : '0;
    return {mq.size() > 0, h[W], h[W-1:0], m_fd, m_ovf, 2'(m_cnt)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    int n = 0;
    input_result = '0;
    out_ready = 1'b1;
    while (mq.size() != 0 || m_drain || m_cnt != 0 || m_cap[W] || m_fd) begin
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL settle obs got %h exp %h", dut_obs(), mdl_obs());
      end
      n++;
      if (n > 60) begin
        errors++; $display("FAIL settle timeout got busy exp idle");
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; input_result = '0;
    tick(); tick();
    checks++;
    if ({out_valid, frame_done, overflow, result_count} !== 5'b0) begin
      errors++; $display("FAIL reset outputs got %b exp 00000", {out_valid, frame_done, overflow, result_count});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int f0 = fd_cnt;
    popped.delete(); out_ready = 1'b1;
    input_result = {1'b1, 32'd8};  tick();
    input_result = {1'b1, 32'd19}; tick();
    checks++;
    if ({out_valid, out_last, out_data} !== {2'b10, 32'd8}) begin
      errors++; $display("FAIL basic first got %h exp %h", {out_valid, out_last, out_data}, {2'b10, 32'd8});
    end
    input_result = '0; tick();
    checks++;
    if ({out_valid, out_last, out_data} !== {2'b11, 32'd19}) begin
      errors++; $display("FAIL basic second got %h exp %h", {out_valid, out_last, out_data}, {2'b11, 32'd19});
    end
    tick();
    checks++;
    if ({frame_done, overflow, result_count} !== 4'b1000) begin
      errors++; $display("FAIL basic done got %b exp 1000", {frame_done, overflow, result_count});
    end
    settle();
    checks++;
    if (popped.size() != 2 || popped[0] !== 32'd8 || popped[1] !== 32'd19 || fd_cnt - f0 != 1) begin
      errors++; $display("FAIL basic popped got n=%0d fd=%0d exp n=2 fd=1", popped.size(), fd_cnt - f0);
    end
  endtask

  task automatic test_filter();
    logic [W:0] seq[4];
    seq[0] = {1'b0, 32'd100}; seq[1] = {1'b1, 32'd6};
    seq[2] = {1'b0, 32'd45};  seq[3] = {1'b1, 32'd55};
    popped.delete(); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      input_result = seq[i];
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL filter obs got %h exp %h", dut_obs(), mdl_obs());
      end
    end
    settle();
    checks++;
    if (popped.size() != 2 || popped[0] !== 32'd6 || popped[1] !== 32'd55) begin
      errors++; $display("FAIL filter popped got n=%0d exp n=2 (6,55)", popped.size());
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    int f0 = fd_cnt;
    a = $urandom; b = $urandom;
    popped.delete(); out_ready = 1'b0;
    input_result = {1'b1, a}; tick();
    input_result = {1'b1, b}; tick();
    input_result = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({out_valid, out_data} !== {1'b1, a} || dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL backpressure hold got %h exp %h", {out_valid, out_data}, {1'b1, a});
      end
    end
    settle();
    checks++;
    if (popped.size() != 2 || popped[0] !== a || popped[1] !== b || fd_cnt - f0 != 1) begin
      errors++; $display("FAIL backpressure order got n=%0d fd=%0d exp n=2 fd=1", popped.size(), fd_cnt - f0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      input_result = {($urandom_range(0, 99) < 40), 32'($urandom)};
      out_ready    = ($urandom_range(0, 99) < 60);
      input_enable = 1'($urandom);
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL random obs cycle %0d got %h exp %h", i, dut_obs(), mdl_obs());
      end
    end
    settle();
  endtask

  task automatic test_excess();
    logic [W-1:0] a, b;
    a = $urandom; b = $urandom;
    rst = 1'b1; tick(); rst = 1'b0;
    popped.delete(); out_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL excess pre_ovf got %b exp 0", overflow);
    end
    input_result = {1'b1, a};     tick();
    input_result = {1'b1, b};     tick();
    input_result = {1'b1, 32'd7}; tick();
    input_result = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL excess obs got %h exp %h", dut_obs(), mdl_obs());
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL excess ovf got %b exp 1", overflow);
    end
    settle();
    checks++;
    if (popped.size() != 2 || popped[0] !== a || popped[1] !== b || overflow !== 1'b1) begin
      errors++; $display("FAIL excess popped got n=%0d ovf=%b exp n=2 ovf=1", popped.size(), overflow);
    end
  endtask

  task automatic test_reset_midframe();
    int f0;
    out_ready = 1'b0;
    input_result = {1'b1, 32'd8}; tick();
    input_result = '0; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    f0 = fd_cnt;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, frame_done, result_count, overflow} !== 5'b0) begin
        errors++; $display("FAIL midreset state got %b exp 00000", {out_valid, frame_done, result_count, overflow});
      end
    end
    popped.delete(); out_ready = 1'b1;
    input_result = {1'b1, 32'd3}; tick();
    input_result = {1'b1, 32'd4}; tick();
    settle();
    checks++;
    if (popped.size() != 2 || popped[0] !== 32'd3 || popped[1] !== 32'd4 || fd_cnt - f0 != 1) begin
      errors++; $display("FAIL midreset frame got n=%0d fd=%0d exp n=2 fd=1", popped.size(), fd_cnt - f0);
    end
  endtask

  task automatic test_overflow_small();
    rdy2 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in2 = {1'b1, 32'(i)};
      tick();
    end
    in2 = '0;
    tick(); tick();
    checks++;
    if ({v2, d2, ov2, rc2} !== {1'b1, 32'd1, 1'b1, 3'd2}) begin
      errors++; $display("FAIL small_ovf held got %h exp %h", {v2, d2, ov2, rc2}, {1'b1, 32'd1, 1'b1, 3'd2});
    end
    rdy2 = 1'b1; tick();
    checks++;
    if ({v2, d2} !== {1'b1, 32'd2}) begin
      errors++; $display("FAIL small_ovf second got %h exp %h", {v2, d2}, {1'b1, 32'd2});
    end
    tick();
    checks++;
    if ({v2, ov2, fd2} !== 3'b010) begin
      errors++; $display("FAIL small_ovf after got %b exp 010", {v2, ov2, fd2});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_backpressure();
    test_random();
    test_excess();
    test_reset_midframe();
    test_overflow_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
